// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer feeding the registered 1-bit full adder `fa` LSB-first.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq #(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_ci,
  input  logic         fa_s,
  input  logic         fa_co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  // state | meaning
  // IDLE  | ready for operands
  // RUN   | driving bit k of a/b into fa, collecting s_{k-1}
  // DRAIN | fa holds last bit; capture MSB sum and carry-out
  // DONE  | result presented until out_ready

  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic [W-1:0]  a_sh, b_sh;
  logic          cin_r;
  logic          last_bit;

`ifdef SERIAL_ADD_OVF_EN
  logic          c_msb;
`endif

  assign last_bit = (k == KW'(W - 1));

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        fa_a  = a_sh[0];
        fa_b  = b_sh[0];
        // fa registers its carry, so bit k's carry-in comes straight back from fa_co
        fa_ci = (k == '0) ? cin_r : fa_co;
        if (last_bit) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      k         <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      cin_r     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      c_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            cin_r <= cin;
            k     <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          k    <= k + KW'(1);
          if (k != '0) sum <= {fa_s, sum[W-1:1]};
`ifdef SERIAL_ADD_OVF_EN
          if (last_bit) c_msb <= fa_ci;
`endif
        end
        DRAIN: begin
          sum       <= {fa_s, sum[W-1:1]};
          cout      <= fa_co;
          out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          ovf       <= c_msb ^ fa_co;
`endif
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Bit-serial add sequencer wrapped around the 1-bit latched full adder `fa`.
- Accepts two W-bit operands plus carry-in over a valid/ready handshake.
- Drives `fa` LSB-first, one bit per clock, and feeds `fa`'s latched `co` back as the next `ci`.
- Collects `fa`'s latched `s` into a parallel W-bit sum, then presents it with carry-out over an output valid/ready handshake.
- Sits directly upstream of `fa` (drives a/b/ci) and directly downstream of it (consumes s/co).

Parameters:
- W, 8, operand/sum width in bits; legal range W >= 2.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; same net drives `fa.rst`.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE while rst is low.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- sum  out  W  result sum.
- cout  out  1  result carry-out.
- fa_a  out  1  to `fa.a`.
- fa_b  out  1  to `fa.b`.
- fa_ci  out  1  to `fa.ci`.
- fa_s  in  1  from `fa.s`; registered in `fa`, one cycle latency.
- fa_co  in  1  from `fa.co`; registered in `fa`, one cycle latency.

Behaviour:
- Reset values (asynchronous): state=IDLE, bit counter=0, operand shift regs=0, sum=0, cout=0, out_valid=0, fa_a/fa_b/fa_ci=0.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_valid && in_ready at edge E0: latch op_a, op_b, cin; clear counter k; go to RUN.
  - fa_a/fa_b/fa_ci driven 0.
- RUN, cycle k = 0..W-1:
  - fa_a = a_sh[0], fa_b = b_sh[0].
  - fa_ci = cin_r when k==0, else fa_co (`fa`'s latched carry of bit k-1).
  - At each RUN edge: shift a_sh/b_sh right; k++.
  - For k>=1, fa_s holds s_{k-1}; shift it into the sum MSB side so that sum[k-1]=s_{k-1} at completion.
  - At the edge ending k=W-1: go to DRAIN.
- DRAIN, one cycle:
  - fa_a/fa_b/fa_ci = 0.
  - At the edge: capture fa_s as sum[W-1] and fa_co as cout; set out_valid=1; go to DONE.
- DONE:
  - sum, cout, out_valid held stable; in_ready=0.
  - out_valid && out_ready at an edge: out_valid=0, go to IDLE.
  - No new accept in that same cycle; in_ready rises the following cycle.
- Latency: out_valid rises exactly W+1 clocks after the acceptance edge E0. Minimum throughput is one add per W+3 clocks.
- sum/cout are not cleared on handshake; they hold the last result until overwritten at the next DRAIN.
- in_valid while not in_ready is ignored; operands are not sampled.
- Operands changing after E0 have no effect.
- rst asserted mid-RUN/DRAIN/DONE: immediate return to reset values; partial result discarded; `fa` also clears, so no stale carry leaks into the next add.
- Wrap-around: the unsigned result is modulo 2^W, with the carry reported on cout.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port `ovf` (1 bit), reset 0.
  - During the RUN cycle with k=W-1, capture fa_ci (carry into the MSB) into c_msb.
  - In DRAIN, ovf = c_msb XOR fa_co (signed two's-complement overflow).
  - ovf updates and holds alongside sum/cout.
- Undefined: no `ovf` port, no c_msb register; all other behaviour identical.

Test Plan:
- W=8, reset then in_valid with op_a=0x5A, op_b=0x3C, cin=0 -> out_valid rises 9 clocks after accept; sum=0x96, cout=0; ovf=1 when SERIAL_ADD_OVF_EN is defined.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; ovf=0. Same pair with cin=1 -> sum=0x01, cout=1.
- op_a=0x00, op_b=0x00, cin=1 -> sum=0x01, cout=0 (carry-in used on bit 0 only); then the full 3-bit a/b/ci truth table checked on fa_a/fa_b/fa_ci/fa_s per cycle.
- Backpressure: result 0x80+0x80 with out_ready held low 5 cycles -> sum=0x00, cout=1 (ovf=1) stable for all 5 cycles; in_ready=0 and in_valid pulses ignored. out_ready=1 -> one-cycle handshake, in_ready=1 next cycle.
- Assert rst for one cycle during RUN at k=4 of 0xAA+0x55 -> all outputs return to reset values asynchronously; next add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
- Back-to-back: in_valid held high across two operand sets -> second accepted only once IDLE is re-entered; both results correct with no carry contamination.
